// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Package  : synth_pkg
// Summary  : Shared waveform codes, sequencer states and a clamp helper for
//            the multi-voice synthesiser.
// Revision : 1.0
// ============================================================================
package synth_pkg;

    localparam logic [1:0] WAVE_OFF    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } synth_state_t;

    // Clamp an unsigned value to the largest code representable in 'width' bits.
    function automatic logic [31:0] saturate(input logic [31:0] value, input int unsigned width);
        logic [31:0] limit;
        limit = (32'd1 << width) - 32'd1;
        return (value > limit) ? limit : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : audio_pwm_out
// Summary  : Free-running PWM frame counter, level latch and comparator;
//            flags the first cycle of every frame.
// Revision : 1.0
// ============================================================================
module audio_pwm_out #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ena,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_frame_start,
    output logic                o_pwm
);

    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic [SAMPLE_W-1:0] r_pwm_level;
    logic [SAMPLE_W-1:0] w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt   <= '0;
            r_pwm_level <= '0;
        end else if (i_ena) begin
            r_pwm_cnt <= r_pwm_cnt + SAMPLE_W'(1);
            if (r_pwm_cnt == '0)
                r_pwm_level <= i_sample;
        end
    end

    // The level latched at count 0 already governs count 0 itself, so a frame
    // holds the output high for exactly 'level' of its 2**SAMPLE_W cycles.
    assign w_level       = (r_pwm_cnt == '0) ? i_sample : r_pwm_level;
    assign o_frame_start = i_ena && (r_pwm_cnt == '0);
    assign o_pwm         = i_ena && (r_pwm_cnt < w_level);

endmodule
`default_nettype wire

// File: rtl/multi_voice_synth.sv
`default_nettype none
// ============================================================================
// Module   : multi_voice_synth
// Summary  : NUM_VOICES phase-accumulator tone voices mixed once per PWM frame
//            through one shared datapath. Define ENVELOPE_EN for a decay envelope.
// Revision : 1.0
// ============================================================================
module multi_voice_synth
    import synth_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    parameter  int PHASE_W    = 16,
    parameter  int SAMPLE_W   = 8,
    parameter  int VOL_W      = 4,
    parameter  int ENV_DIV    = 64,
    localparam int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                play,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [VIDX_W-1:0]   cfg_voice,
    input  logic [1:0]          cfg_wave,
    input  logic [PHASE_W-1:0]  cfg_incr,
    input  logic [VOL_W-1:0]    cfg_vol,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_strobe,
    output logic                pwm_out
);

    localparam int c_acc_w = SAMPLE_W + $clog2(NUM_VOICES) + 1;

    logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]        r_incr  [NUM_VOICES];
    logic [VOL_W-1:0]          r_vol   [NUM_VOICES];
    logic [1:0]                r_wave  [NUM_VOICES];
    synth_state_t              r_state;
    synth_state_t              w_state_nxt;
    logic [VIDX_W-1:0]         r_idx;
    logic [c_acc_w-1:0]        r_acc;
    logic [SAMPLE_W-1:0]       r_sample;
    logic                      r_strobe;
    logic                      w_frame_start;
    logic                      w_cfg_fire;
    logic [SAMPLE_W-1:0]       w_p;
    logic [SAMPLE_W-1:0]       w_wave_val;
    logic [SAMPLE_W-1:0]       w_term;
    logic [VOL_W-1:0]          w_vol_eff;
    logic [SAMPLE_W+VOL_W-1:0] w_prod;

    assign cfg_ready     = ena && (r_state != SWEEP);
    assign w_cfg_fire    = cfg_valid && cfg_ready && (int'(cfg_voice) < NUM_VOICES);
    assign sample_out    = r_sample;
    assign sample_strobe = r_strobe;

    audio_pwm_out #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pwm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (ena),
        .i_sample      (r_sample),
        .o_frame_start (w_frame_start),
        .o_pwm         (pwm_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (ena)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_frame_start) w_state_nxt = SWEEP;
            SWEEP:   if (r_idx == VIDX_W'(NUM_VOICES - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Waveform of the voice currently selected by the sweep index.
    always_comb begin
        w_wave_val = '0;
        w_p        = r_phase[r_idx][PHASE_W-1 -: SAMPLE_W];
        case (r_wave[r_idx])
            WAVE_SQUARE: w_wave_val = {SAMPLE_W{w_p[SAMPLE_W-1]}};
            WAVE_SAW:    w_wave_val = w_p;
            WAVE_TRI:    w_wave_val = w_p[SAMPLE_W-1] ? ~{w_p[SAMPLE_W-2:0], 1'b0}
                                                      :  {w_p[SAMPLE_W-2:0], 1'b0};
            default:     w_wave_val = '0;
        endcase
        w_prod = (SAMPLE_W+VOL_W)'(w_wave_val) * (SAMPLE_W+VOL_W)'(w_vol_eff);
        w_term = play ? SAMPLE_W'(w_prod >> VOL_W) : '0;
    end

`ifdef ENVELOPE_EN
    localparam int c_div_w = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    logic [VOL_W-1:0]   r_env [NUM_VOICES];
    logic [c_div_w-1:0] r_env_cnt;
    logic [2*VOL_W-1:0] w_env_prod;

    assign w_env_prod = (2*VOL_W)'(r_vol[r_idx]) * (2*VOL_W)'(r_env[r_idx]);
    assign w_vol_eff  = VOL_W'(w_env_prod >> VOL_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_env_cnt <= '0;
            for (int v = 0; v < NUM_VOICES; v++)
                r_env[v] <= '0;
        end else if (ena) begin
            if (r_state == DONE) begin
                if (r_env_cnt == c_div_w'(ENV_DIV - 1)) begin
                    r_env_cnt <= '0;
                    for (int v = 0; v < NUM_VOICES; v++)
                        if (r_env[v] != '0)
                            r_env[v] <= r_env[v] - VOL_W'(1);
                end else begin
                    r_env_cnt <= r_env_cnt + c_div_w'(1);
                end
            end
            // A note-on restarts the decay, overriding a same-cycle decrement.
            if (w_cfg_fire && (cfg_wave != WAVE_OFF))
                r_env[cfg_voice] <= '1;
        end
    end
`else
    assign w_vol_eff = r_vol[r_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
                r_incr[v]  <= '0;
                r_vol[v]   <= '0;
                r_wave[v]  <= WAVE_OFF;
            end
            r_idx    <= '0;
            r_acc    <= '0;
            r_sample <= '0;
            r_strobe <= 1'b0;
        end else if (ena) begin
            r_strobe <= (r_state == DONE);
            case (r_state)
                SWEEP: begin
                    r_acc <= r_acc + c_acc_w'(w_term);
                    r_idx <= r_idx + VIDX_W'(1);
                    if (play && (r_wave[r_idx] != WAVE_OFF))
                        r_phase[r_idx] <= r_phase[r_idx] + r_incr[r_idx];
                end
                DONE: begin
                    r_sample <= play ? SAMPLE_W'(saturate(32'(r_acc), SAMPLE_W)) : '0;
                    r_acc    <= '0;
                end
                default: r_idx <= '0;
            endcase
            if (w_cfg_fire) begin
                r_wave[cfg_voice] <= cfg_wave;
                r_incr[cfg_voice] <= cfg_incr;
                r_vol[cfg_voice]  <= cfg_vol;
                if (cfg_wave != WAVE_OFF)
                    r_phase[cfg_voice] <= '0;
            end
            // Gating playback parks every voice at phase 0 so a restart is in sync.
            if (!play) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    r_phase[v] <= '0;
                r_acc <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_voice_synth.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_voice_synth
// Summary  : Randomised bench for multi_voice_synth against a frame-level
//            arithmetic model of the voices, mixer and PWM duty.
// Revision : 1.0
// ============================================================================
module tb_multi_voice_synth;

    localparam int NV      = 4;
    localparam int ENV_DIV = 64;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        ena       = 1'b1;
    logic        play      = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_voice = '0;
    logic [1:0]  cfg_wave  = '0;
    logic [15:0] cfg_incr  = '0;
    logic [3:0]  cfg_vol   = '0;
    logic [7:0]  sample_out;
    logic        sample_strobe;
    logic        pwm_out;

    multi_voice_synth #(
        .NUM_VOICES (NV),
        .PHASE_W    (16),
        .SAMPLE_W   (8),
        .VOL_W      (4),
        .ENV_DIV    (ENV_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .play          (play),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_voice     (cfg_voice),
        .cfg_wave      (cfg_wave),
        .cfg_incr      (cfg_incr),
        .cfg_vol       (cfg_vol),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .pwm_out       (pwm_out)
    );

    always #5 clk = ~clk;

    // Reference model: per-voice settings plus the frame position (0..255).
    int m_phase [NV];
    int m_incr  [NV];
    int m_vol   [NV];
    int m_wave  [NV];
    int m_env   [NV];
    int m_acc, m_sample, m_level, m_cnt, m_env_frames, tally;
    bit strobe_due, accepted;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int voice_term(input int v);
        int p, w, ve;
        p = (m_phase[v] >> 8) & 255;
        case (m_wave[v])
            1:       w = (p >= 128) ? 255 : 0;
            2:       w = p;
            3:       w = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            default: w = 0;
        endcase
`ifdef ENVELOPE_EN
        ve = (m_vol[v] * m_env[v]) / 16;
`else
        ve = m_vol[v];
`endif
        return (w * ve) / 16;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_incr[v] = 0; m_vol[v] = 0; m_wave[v] = 0; m_env[v] = 0;
        end
        m_acc = 0; m_sample = 0; m_level = 0; m_cnt = 0; m_env_frames = 0; tally = 0;
        strobe_due = 0;
    endtask

    task automatic observe();
        if (!rst_n) begin
            check_eq("rst_pwm", int'(pwm_out), 0);
            check_eq("rst_sample", int'(sample_out), 0);
            check_eq("rst_strobe", int'(sample_strobe), 0);
            check_eq("rst_cfg_ready", int'(cfg_ready), 1);
        end else if (!ena) begin
            check_eq("ena0_pwm", int'(pwm_out), 0);
            check_eq("ena0_cfg_ready", int'(cfg_ready), 0);
        end else begin
            if (m_cnt <= NV + 3) begin
                check_eq("cfg_ready", int'(cfg_ready), (m_cnt >= 1 && m_cnt <= NV) ? 0 : 1);
                check_eq("strobe", int'(sample_strobe), int'(strobe_due));
            end
            if (strobe_due)
                check_eq("sample", int'(sample_out), m_sample);
            if (m_cnt == 0)
                tally = 0;
            tally += int'(pwm_out);
            if (m_cnt == 255)
                check_eq("pwm_duty", tally, m_level);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then check.
    task automatic step();
        bit in_sweep;
        int v;
        @(posedge clk);
        accepted = 0;
        if (!rst_n) begin
            model_reset();
        end else if (ena) begin
            in_sweep = (m_cnt >= 1 && m_cnt <= NV);
            if (m_cnt == NV + 1) begin
                m_sample = play ? ((m_acc > 255) ? 255 : m_acc) : 0;
                m_acc    = 0;
`ifdef ENVELOPE_EN
                if (m_env_frames == ENV_DIV - 1) begin
                    m_env_frames = 0;
                    for (int k = 0; k < NV; k++) if (m_env[k] > 0) m_env[k]--;
                end else begin
                    m_env_frames++;
                end
`endif
            end
            if (cfg_valid && !in_sweep) begin
                accepted = 1;
                v = int'(cfg_voice);
                m_wave[v] = int'(cfg_wave);
                m_incr[v] = int'(cfg_incr);
                m_vol[v]  = int'(cfg_vol);
                if (cfg_wave != 0) begin
                    m_phase[v] = 0;
                    m_env[v]   = 15;
                end
            end
            if (in_sweep && play) begin
                v = m_cnt - 1;
                m_acc += voice_term(v);
                if (m_wave[v] != 0) m_phase[v] = (m_phase[v] + m_incr[v]) % 65536;
            end
            if (!play) begin
                for (int k = 0; k < NV; k++) m_phase[k] = 0;
                m_acc = 0;
            end
            strobe_due = (m_cnt == NV + 1);
            m_cnt = (m_cnt + 1) % 256;
            if (m_cnt == 0) m_level = m_sample;
        end
        #1;
        observe();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic step_until(input int cnt);
        for (int k = 0; k < 600; k++) begin
            step();
            if (m_cnt == cnt) return;
        end
        check_eq("frame_pos_timeout", m_cnt, cnt);
    endtask

    task automatic next_sample(output int s);
        s = -1;
        for (int k = 0; k < 600; k++) begin
            step();
            if (strobe_due) begin
                s = int'(sample_out);
                return;
            end
        end
        check_eq("strobe_timeout", 0, 1);
    endtask

    task automatic cfg_write(input int v, input int w, input int inc, input int vol, output int waits);
        cfg_valid = 1'b1;
        cfg_voice = 2'(v);
        cfg_wave  = 2'(w);
        cfg_incr  = 16'(inc);
        cfg_vol   = 4'(vol);
        waits     = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (accepted) break;
            waits++;
        end
        if (!accepted) check_eq("cfg_accept_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int s, waits;
        model_reset();
        do_reset();

        // Single square voice alternates between silence and full-scale*15/16.
        play = 1'b1;
        cfg_write(0, 1, 16'h8000, 15, waits);
        for (int i = 0; i < 4; i++) begin
            next_sample(s);
`ifndef ENVELOPE_EN
            check_eq("square_seq", s, (i % 2) ? 239 : 0);
`endif
        end

        // Four in-phase squares exceed the sample range and must clamp.
        step_until(10);
        for (int v = 0; v < NV; v++) cfg_write(v, 1, 16'h8000, 15, waits);
        for (int i = 0; i < 4; i++) begin
            next_sample(s);
`ifndef ENVELOPE_EN
            check_eq("saturate_seq", s, (i % 2) ? 255 : 0);
`endif
        end

        // Request raised in the first sweep cycle waits out the sweep.
        for (int v = 1; v < NV; v++) cfg_write(v, 0, 0, 0, waits);
        step_until(1);
        cfg_write(0, 1, 16'h8000, 8, waits);
        check_eq("handshake_wait", waits, 4);
        for (int i = 0; i < 2; i++) begin
            next_sample(s);
`ifndef ENVELOPE_EN
            check_eq("new_vol_seq", s, (i % 2) ? 127 : 0);
`endif
        end

        // Dropping play mid-sweep silences the frame; resuming restarts at phase 0.
        step_until(2);
        play = 1'b0;
        next_sample(s);
        check_eq("play_off_sample", s, 0);
        run(300);
        step_until(10);
        play = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_sample(s);
`ifndef ENVELOPE_EN
            check_eq("play_restart_seq", s, (i % 2) ? 127 : 0);
`endif
        end

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1: cfg_write($urandom_range(0, NV - 1), $urandom_range(0, 3),
                                $urandom_range(0, 65535), $urandom_range(0, 15), waits);
                2: run($urandom_range(50, 600));
                3: begin
                    play = ($urandom_range(0, 3) != 0);
                    run($urandom_range(1, 300));
                end
                4: begin
                    step_until($urandom_range(20, 180));
                    ena = 1'b0;
                    run($urandom_range(1, 20));
                    ena = 1'b1;
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) do_reset();
                    else run(100);
                end
            endcase
        end

        step_until(100);
        do_reset();
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
